pe_vinsn_queue: RTL and testbench

Per-PE instruction queue directly downstream of `ara_sequencer`. It accepts the broadcast `pe_req_t` stream and keeps only requests whose `vfu` matches this PE. Each kept request waits in order until its hazard bits are cleared by completion pulses from the other PEs, and is then handed to the local functional unit. On completion it returns the one-hot `vinsn_done` pulse that the sequencer uses to retire the instruction.

---
 rtl/ara_pkg.sv | 35 +++
 rtl/pe_vinsn_queue_pkg.sv | 16 +
 rtl/pe_vinsn_queue_ptr.sv | 32 +++
 rtl/pe_vinsn_queue.sv | 125 ++++++++++++
 tb/tb_pe_vinsn_queue.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ara_pkg.sv
// Shared Ara sequencer/PE types as seen by the per-PE instruction queues.
// Only the fields these queues consume are modelled here.
package ara_pkg;

  localparam int unsigned NrVInsn = 8;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;

  typedef enum logic [2:0] {
    VFU_None      = 3'd0,
    VFU_Alu       = 3'd1,
    VFU_MFpu      = 3'd2,
    VFU_SlideUnit = 3'd3,
    VFU_MaskUnit  = 3'd4,
    VFU_LoadUnit  = 3'd5,
    VFU_StoreUnit = 3'd6
  } vfu_e;

  typedef struct packed {
    vid_t               id;
    vfu_e               vfu;
    logic               vm;
    logic [7:0]         op;
    logic [4:0]         vd;
    logic [NrVInsn-1:0] hazard_vs1;
    logic [NrVInsn-1:0] hazard_vs2;
    logic [NrVInsn-1:0] hazard_vd;
    logic [NrVInsn-1:0] hazard_vm;
  } pe_req_t;

  typedef struct packed {
    logic [NrVInsn-1:0] vinsn_done;
  } pe_resp_t;

endpackage

// File: rtl/pe_vinsn_queue_pkg.sv
// Helpers shared by the per-PE instruction queue.
// ID decode and hazard-mask extraction.
package pe_vinsn_queue_pkg;
  import ara_pkg::*;

  function automatic logic [NrVInsn-1:0] vid_onehot(vid_t id);
    vid_onehot     = '0;
    vid_onehot[id] = 1'b1;
  endfunction

  function automatic logic [NrVInsn-1:0] hazard_mask(pe_req_t r);
    hazard_mask = r.hazard_vs1 | r.hazard_vs2
                | r.hazard_vd  | r.hazard_vm;
  endfunction

endpackage

// File: rtl/pe_vinsn_queue_ptr.sv
// Wrapping pointer with an up/down occupancy counter.
// The counter reset value lets one instance track free slots.
module pe_vinsn_queue_ptr #(
  parameter int unsigned Depth   = 4,
  parameter int unsigned CntInit = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     inc_i,
  input  logic                     dec_i,
  output logic [$clog2(Depth)-1:0] ptr_o,
  output logic [$clog2(Depth):0]   cnt_o
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = PW + 1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_o <= '0;
      cnt_o <= CW'(CntInit);
    end else begin
      if (inc_i) ptr_o <= ptr_o + PW'(1);
      unique case ({inc_i, dec_i})
        2'b10:   cnt_o <= cnt_o + CW'(1);
        2'b01:   cnt_o <= cnt_o - CW'(1);
        default: cnt_o <= cnt_o;
      endcase
    end
  end

endmodule

// File: rtl/pe_vinsn_queue.sv
// In-order per-PE instruction queue: filters the sequencer broadcast,
// waits out hazards, issues to the unit and reports completion.
module pe_vinsn_queue
  import ara_pkg::*;
  import pe_vinsn_queue_pkg::*;
#(
  parameter int unsigned NrLanes    = 1,
  parameter vfu_e        VfuSel     = VFU_Alu,
  parameter int unsigned QueueDepth = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  pe_req_t            pe_req_i,
  input  logic               pe_req_valid_i,
  output logic               pe_req_ready_o,
  input  logic [NrVInsn-1:0] done_all_i,
  output pe_req_t            unit_req_o,
  output logic               unit_req_valid_o,
  input  logic               unit_req_ready_i,
  input  logic               unit_done_i,
  output pe_resp_t           pe_resp_o,
  output logic               busy_o
);

  localparam int unsigned PW = $clog2(QueueDepth);
  localparam int unsigned CW = PW + 1;

  if (QueueDepth < 2 || (QueueDepth & (QueueDepth - 1)) != 0
      || NrLanes == 0) begin : g_cfg_err
    $error("pe_vinsn_queue: unsupported parameters");
  end

  pe_req_t            req_q   [QueueDepth];
  logic [NrVInsn-1:0] hmask_q [QueueDepth];
  logic [NrVInsn-1:0] id_present;

  logic [PW-1:0] wr_ptr, iss_ptr, cmt_ptr;
  logic [CW-1:0] cnt, iss_cnt, free_cnt;

  logic    match, dup, ready;
  logic    accept, issue_ok, issue, commit;
  pe_req_t head;

  assign match = (pe_req_i.vfu == VfuSel)
              || (VfuSel == VFU_MaskUnit && !pe_req_i.vm);
  assign dup   = id_present[pe_req_i.id];
  assign ready = !match || dup || free_cnt != '0;

  assign accept = !rst_i && pe_req_valid_i && match
               && !dup && free_cnt != '0;
  assign issue_ok = (cnt > iss_cnt)
                 && hmask_q[iss_ptr] == '0;
  assign issue  = !rst_i && issue_ok && unit_req_ready_i;
  assign commit = !rst_i && unit_done_i && iss_cnt != '0;

  pe_vinsn_queue_ptr #(.Depth(QueueDepth)) u_wr (
    .clk_i, .rst_i,
    .inc_i (accept),
    .dec_i (commit),
    .ptr_o (wr_ptr),
    .cnt_o (cnt)
  );

  pe_vinsn_queue_ptr #(.Depth(QueueDepth)) u_iss (
    .clk_i, .rst_i,
    .inc_i (issue),
    .dec_i (commit),
    .ptr_o (iss_ptr),
    .cnt_o (iss_cnt)
  );

  // Commit side counts free slots, so its counter starts full.
  pe_vinsn_queue_ptr #(
    .Depth   (QueueDepth),
    .CntInit (QueueDepth)
  ) u_cmt (
    .clk_i, .rst_i,
    .inc_i (commit),
    .dec_i (accept),
    .ptr_o (cmt_ptr),
    .cnt_o (free_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (accept) req_q[wr_ptr] <= pe_req_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_present <= '0;
      for (int i = 0; i < QueueDepth; i++)
        hmask_q[i] <= '0;
    end else begin
      for (int i = 0; i < QueueDepth; i++)
        hmask_q[i] <= hmask_q[i] & ~done_all_i;
      if (accept)
        hmask_q[wr_ptr] <= hazard_mask(pe_req_i)
                         & ~done_all_i;
      id_present <= (id_present
        | (accept ? vid_onehot(pe_req_i.id) : '0))
        & ~(commit ? vid_onehot(req_q[cmt_ptr].id) : '0);
    end
  end

  always_comb begin
    head            = req_q[iss_ptr];
    head.hazard_vs1 = '0;
    head.hazard_vs2 = '0;
    head.hazard_vd  = '0;
    head.hazard_vm  = '0;
    unit_req_o      = rst_i ? '0 : head;
    pe_resp_o       = '0;
    if (commit)
      pe_resp_o.vinsn_done = vid_onehot(req_q[cmt_ptr].id);
  end

  assign unit_req_valid_o = !rst_i && issue_ok;
  assign pe_req_ready_o   = !rst_i && ready;
  assign busy_o           = !rst_i && cnt != '0;

  assert property (@(posedge clk_i) disable iff (rst_i)
    unit_done_i |-> iss_cnt != '0)
  else $warning("unit_done_i with nothing issued, ignored");

endmodule

// File: tb/tb_pe_vinsn_queue.sv
// Bench for pe_vinsn_queue: queue-level reference model plus
// directed scenarios and randomized sequencer/unit traffic.
module tb_pe_vinsn_queue;
  import ara_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  pe_req_t            req;
  logic               req_valid;
  logic [NrVInsn-1:0] done_all;
  logic               unit_ready;
  logic               unit_done;

  logic     ready, uvalid, busy;
  pe_req_t  ureq;
  pe_resp_t resp;

  logic     m_ready, m_uvalid, m_busy;
  pe_req_t  m_ureq;
  pe_resp_t m_resp;

  always #5 clk = ~clk;

  pe_vinsn_queue #(
    .NrLanes(1), .VfuSel(VFU_Alu), .QueueDepth(4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pe_req_i         (req),
    .pe_req_valid_i   (req_valid),
    .pe_req_ready_o   (ready),
    .done_all_i       (done_all),
    .unit_req_o       (ureq),
    .unit_req_valid_o (uvalid),
    .unit_req_ready_i (unit_ready),
    .unit_done_i      (unit_done),
    .pe_resp_o        (resp),
    .busy_o           (busy)
  );

  pe_vinsn_queue #(
    .NrLanes(1), .VfuSel(VFU_MaskUnit), .QueueDepth(4)
  ) dut_m (
    .clk_i            (clk),
    .rst_i            (rst),
    .pe_req_i         (req),
    .pe_req_valid_i   (req_valid),
    .pe_req_ready_o   (m_ready),
    .done_all_i       (done_all),
    .unit_req_o       (m_ureq),
    .unit_req_valid_o (m_uvalid),
    .unit_req_ready_i (1'b0),
    .unit_done_i      (1'b0),
    .pe_resp_o        (m_resp),
    .busy_o           (m_busy)
  );

  typedef struct {
    pe_req_t            req;
    logic [NrVInsn-1:0] hm;
  } ment_t;

  ment_t q[$];
  int    iss_n = 0;
  bit    hs = 0;
  int    issued_ids[$];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit present(vid_t id);
    foreach (q[i]) if (q[i].req.id == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NrVInsn-1:0] oh(int b);
    return NrVInsn'(1) << b;
  endfunction

  function automatic pe_req_t mk(int id, vfu_e vfu, bit vm,
                                 logic [NrVInsn-1:0] hz);
    pe_req_t r;
    r            = '0;
    r.id         = vid_t'(id);
    r.vfu        = vfu;
    r.vm         = vm;
    r.op         = 8'($urandom);
    r.vd         = 5'($urandom);
    r.hazard_vs1 = hz;
    return r;
  endfunction

  function automatic pe_req_t rnd_req();
    pe_req_t r;
    int      s;
    vfu_e    v;
    s = $urandom_range(0, 7);
    if (s < 5)       v = VFU_Alu;
    else if (s == 5) v = VFU_LoadUnit;
    else if (s == 6) v = VFU_MaskUnit;
    else             v = VFU_MFpu;
    r = mk($urandom_range(0, 7), v, 1'($urandom),
           ($urandom_range(0, 2) == 0)
             ? oh($urandom_range(0, 7)) : '0);
    if ($urandom_range(0, 5) == 0)
      r.hazard_vs2 = oh($urandom_range(0, 7));
    if ($urandom_range(0, 5) == 0)
      r.hazard_vd = oh($urandom_range(0, 7));
    if ($urandom_range(0, 5) == 0)
      r.hazard_vm = oh($urandom_range(0, 7));
    return r;
  endfunction

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Called at the negedge: compare, advance the model, cross posedge.
  task automatic tick();
    bit                 m, p, e_ready, e_valid;
    bit                 acc, iss, cmt;
    logic [NrVInsn-1:0] e_done;
    pe_req_t            e_req;
    ment_t              e;
    chk("mask_resp", 64'(m_resp), 64'(0));
    if (rst) begin
      chk("rst_ready", 64'(ready), 64'(0));
      chk("rst_valid", 64'(uvalid), 64'(0));
      chk("rst_ureq", 64'(ureq), 64'(0));
      chk("rst_resp", 64'(resp), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      q.delete();
      iss_n = 0;
      hs    = 1'b0;
    end else begin
      m       = req.vfu == VFU_Alu;
      p       = present(req.id);
      e_ready = !m || p || q.size() < 4;
      e_valid = 1'b0;
      if (q.size() > iss_n) e_valid = q[iss_n].hm == '0;
      e_done  = '0;
      if (unit_done && iss_n > 0) e_done = oh(int'(q[0].req.id));
      chk("ready", 64'(ready), 64'(e_ready));
      chk("valid", 64'(uvalid), 64'(e_valid));
      if (e_valid) begin
        e_req            = q[iss_n].req;
        e_req.hazard_vs1 = '0;
        e_req.hazard_vs2 = '0;
        e_req.hazard_vd  = '0;
        e_req.hazard_vm  = '0;
        chk("unit_req", 64'(ureq), 64'(e_req));
      end
      chk("vinsn_done", 64'(resp.vinsn_done), 64'(e_done));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      hs  = req_valid && e_ready;
      acc = hs && m && !p;
      iss = e_valid && unit_ready;
      cmt = unit_done && iss_n > 0;
      foreach (q[i]) q[i].hm &= ~done_all;
      if (iss) begin
        issued_ids.push_back(int'(q[iss_n].req.id));
        iss_n++;
      end
      if (cmt) begin
        void'(q.pop_front());
        iss_n--;
      end
      if (acc) begin
        e.req = req;
        e.hm  = (req.hazard_vs1 | req.hazard_vs2
              | req.hazard_vd | req.hazard_vm) & ~done_all;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    tick();
  endtask

  task automatic drain();
    req_valid  = 1'b0;
    unit_ready = 1'b1;
    done_all   = '1;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      unit_done = iss_n > 0;
      step();
    end
    unit_done  = 1'b0;
    unit_ready = 1'b0;
    done_all   = '0;
    at_neg();
    chk("drain_busy", 64'(busy), 64'(0));
    tick();
  endtask

  initial begin
    int hold;
    rst        = 1'b1;
    req        = '0;
    req_valid  = 1'b0;
    done_all   = '0;
    unit_ready = 1'b0;
    unit_done  = 1'b0;
    #1;
    step();
    at_neg();
    chk("reset_ready_lit", 64'(ready), 64'(0));
    tick();

    // Reset/basic
    rst       = 1'b0;
    req       = mk(3, VFU_Alu, 1'b1, '0);
    req_valid = 1'b1;
    at_neg();
    chk("post_reset_ready", 64'(ready), 64'(1));
    tick();
    req_valid  = 1'b0;
    unit_ready = 1'b1;
    at_neg();
    chk("first_valid", 64'(uvalid), 64'(1));
    chk("first_id", 64'(ureq.id), 64'(3));
    tick();
    unit_ready = 1'b0;
    unit_done  = 1'b1;
    at_neg();
    chk("done_pulse", 64'(resp.vinsn_done), 64'(8'b0000_1000));
    tick();
    unit_done = 1'b0;
    at_neg();
    chk("done_once", 64'(resp.vinsn_done), 64'(0));
    tick();

    // Mask-unit instance keeps only masked ops
    req       = mk(7, VFU_Alu, 1'b1, '0);
    req_valid = 1'b1;
    at_neg();
    chk("mask_ignore_ready", 64'(m_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    at_neg();
    chk("mask_ignores_vm1", 64'(m_busy), 64'(0));
    tick();
    req       = mk(5, VFU_Alu, 1'b0, '0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    at_neg();
    chk("mask_keeps_vm0", 64'(m_busy), 64'(1));
    chk("mask_valid", 64'(m_uvalid), 64'(1));
    chk("mask_id", 64'(m_ureq.id), 64'(5));
    tick();
    drain();

    // Duplicate hold
    req       = mk(2, VFU_Alu, 1'b1, '0);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("dup_ready", 64'(ready), 64'(1));
      tick();
    end
    req_valid = 1'b0;
    at_neg();
    chk("dup_cnt", 64'(dut.cnt), 64'(1));
    chk("dup_model", 64'(q.size()), 64'(1));
    tick();
    drain();

    // Full, commit while full, pointer wrap
    for (int i = 0; i < 4; i++) begin
      req       = mk(i, VFU_Alu, 1'b1, '0);
      req_valid = 1'b1;
      step();
    end
    req = mk(4, VFU_Alu, 1'b1, '0);
    at_neg();
    chk("full_ready", 64'(ready), 64'(0));
    tick();
    unit_ready = 1'b1;
    step();
    unit_ready = 1'b0;
    unit_done  = 1'b1;
    at_neg();
    chk("full_commit_ready", 64'(ready), 64'(0));
    tick();
    unit_done = 1'b0;
    at_neg();
    chk("after_commit_ready", 64'(ready), 64'(1));
    tick();
    issued_ids.delete();
    drain();
    chk("wrap_issue_count", 64'(issued_ids.size()), 64'(4));
    if (issued_ids.size() != 0)
      chk("wrap_last_id", 64'(issued_ids[$]), 64'(4));

    // Hazard stall and release
    req       = mk(1, VFU_Alu, 1'b1, 8'h01);
    req_valid = 1'b1;
    step();
    req_valid  = 1'b0;
    unit_ready = 1'b1;
    at_neg();
    chk("haz_stall", 64'(uvalid), 64'(0));
    tick();
    at_neg();
    chk("haz_stall2", 64'(uvalid), 64'(0));
    tick();
    done_all = 8'h01;
    at_neg();
    chk("haz_pulse_cycle", 64'(uvalid), 64'(0));
    tick();
    done_all = '0;
    at_neg();
    chk("haz_release", 64'(uvalid), 64'(1));
    tick();
    drain();

    // Hazard cleared in the accept cycle
    req       = mk(6, VFU_Alu, 1'b1, 8'h01);
    req_valid = 1'b1;
    done_all  = 8'h01;
    step();
    req_valid = 1'b0;
    done_all  = '0;
    at_neg();
    chk("haz_same_cycle", 64'(uvalid), 64'(1));
    tick();
    drain();

    // Filtering
    req       = mk(5, VFU_LoadUnit, 1'b1, '0);
    req_valid = 1'b1;
    at_neg();
    chk("filter_ready", 64'(ready), 64'(1));
    tick();
    req_valid = 1'b0;
    at_neg();
    chk("filter_busy", 64'(busy), 64'(0));
    chk("filter_valid", 64'(uvalid), 64'(0));
    tick();

    // Spurious done
    unit_done = 1'b1;
    at_neg();
    chk("spurious_pulse", 64'(resp.vinsn_done), 64'(0));
    tick();
    unit_done = 1'b0;
    at_neg();
    chk("spurious_busy", 64'(busy), 64'(0));
    chk("spurious_iss_cnt", 64'(dut.iss_cnt), 64'(0));
    tick();

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!req_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          req       = rnd_req();
          req_valid = 1'b1;
          hold      = $urandom_range(0, 2);
        end
      end else if (hs) begin
        if (hold > 0) hold--;
        else if ($urandom_range(0, 1) == 0) begin
          req  = rnd_req();
          hold = $urandom_range(0, 2);
        end else req_valid = 1'b0;
      end
      done_all = ($urandom_range(0, 2) == 0)
               ? oh($urandom_range(0, 7)) : '0;
      unit_ready = 1'($urandom);
      unit_done  = iss_n > 0 && $urandom_range(0, 2) == 0;
      step();
    end

    // Reset in the middle of traffic
    req_valid  = 1'b0;
    unit_done  = 1'b0;
    unit_ready = 1'b0;
    done_all   = '0;
    rst        = 1'b1;
    step();
    step();
    rst = 1'b0;
    at_neg();
    chk("rerun_ready", 64'(ready), 64'(1));
    chk("rerun_busy", 64'(busy), 64'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
